// File: rtl/bram_fifo_pkg.sv
// bram_fifo_pkg: sizing helpers shared by the BRAM-backed FIFO controller and its output buffer.
package bram_fifo_pkg;
    localparam int OBUF_DEPTH = 2;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic int level_width(input int aw);
        return aw + 1;
    endfunction
endpackage

// File: rtl/bram_fifo_obuf.sv
// bram_fifo_obuf: 2-entry in-order queue that absorbs BRAM read returns so the FIFO output is FWFT.
module bram_fifo_obuf #(
    parameter int DWIDTH = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DWIDTH-1:0] head,
    output logic              valid
);
    logic [DWIDTH-1:0] e0, e1;
    logic              do_pop;
    logic [1:0]        base;

    assign valid  = count != 2'd0;
    assign head   = e0;
    assign do_pop = pop && valid;
    assign base   = count - {1'b0, do_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else
            count <= base + {1'b0, push};
    end

    // Pop shifts the tail forward; a push lands in the first slot left free after that shift.
    always_ff @(posedge clk) begin
        e0 <= (push && base == 2'd0) ? push_data : (do_pop ? e1 : e0);
        e1 <= (push && base == 2'd1) ? push_data : e1;
    end
endmodule

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: FWFT FIFO controller driving one BRAM_TDP (port A write-only, port B read-only).
// Defining BRAM_FIFO_ALMOST_EN adds registered almost_full/almost_empty flags.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int AWIDTH    = 10,
    parameter int DWIDTH    = 36,
    parameter int AF_MARGIN = 4,
    parameter int AE_MARGIN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef BRAM_FIFO_ALMOST_EN
    output logic              almost_full,
    output logic              almost_empty,
`endif
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [AWIDTH:0]   level,
    output logic              mem_wce,
    output logic [AWIDTH-1:0] mem_wa,
    output logic [DWIDTH-1:0] mem_wd,
    output logic              mem_rce,
    output logic [AWIDTH-1:0] mem_ra,
    input  logic [DWIDTH-1:0] mem_rq
);
    localparam int DEPTH = fifo_depth(AWIDTH);
    localparam int LW    = level_width(AWIDTH);

    logic              run, inflight, wr, pop;
    logic [AWIDTH-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0]     mem_count, level_n;
    logic [1:0]        ob_count;

    assign s_ready = run && (mem_count != LW'(DEPTH));
    assign wr      = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    // Issue only when the returning word is guaranteed a free output-buffer slot.
    assign mem_rce = (mem_count != '0) &&
                     (({1'b0, ob_count} + {2'b0, inflight} - {2'b0, pop}) < 3'(OBUF_DEPTH));
    assign mem_wce = wr;
    assign mem_wa  = wr_ptr;
    assign mem_wd  = s_data;
    assign mem_ra  = rd_ptr;
    assign level_n = mem_count + LW'(wr) + LW'(ob_count) + LW'(inflight) - LW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            inflight  <= 1'b0;
            level     <= '0;
        end else begin
            run       <= 1'b1;
            wr_ptr    <= wr_ptr + AWIDTH'(wr);
            rd_ptr    <= rd_ptr + AWIDTH'(mem_rce);
            mem_count <= mem_count + LW'(wr) - LW'(mem_rce);
            inflight  <= mem_rce;
            level     <= level_n;
        end
    end

    bram_fifo_obuf #(.DWIDTH(DWIDTH)) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (mem_rq),
        .pop       (pop),
        .count     (ob_count),
        .head      (m_data),
        .valid     (m_valid)
    );

`ifdef BRAM_FIFO_ALMOST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= level_n >= LW'(DEPTH + OBUF_DEPTH - AF_MARGIN);
            almost_empty <= level_n <= LW'(AE_MARGIN);
        end
    end
`else
    logic unused_margins;
    assign unused_margins = ^{AF_MARGIN, AE_MARGIN};
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: randomized self-checking bench; the model is a plain queue of accepted words.
module tb_bram_fifo_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int CAP = 18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, m_valid, mem_wce, mem_rce;
    logic [DW-1:0] m_data, mem_wd, mem_rq;
    logic [AW:0]   level;
    logic [AW-1:0] mem_wa, mem_ra;
`ifdef BRAM_FIFO_ALMOST_EN
    logic          almost_full, almost_empty;
`endif

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] q [$];
    int            wr_total = 0;
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wce) ram[mem_wa] <= mem_wd;
        if (mem_rce) mem_rq <= ram[mem_ra];
    end

    bram_fifo_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .AF_MARGIN(2), .AE_MARGIN(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef BRAM_FIFO_ALMOST_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .level        (level),
        .mem_wce      (mem_wce),
        .mem_wa       (mem_wa),
        .mem_wd       (mem_wd),
        .mem_rce      (mem_rce),
        .mem_ra       (mem_ra),
        .mem_rq       (mem_rq)
    );

    // Commit this cycle's handshakes into the model, then move to the next negedge.
    task automatic adv();
        if (m_valid && m_ready && q.size() != 0) void'(q.pop_front());
        if (s_valid && s_ready) begin
            q.push_back(s_data);
            wr_total++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk); #1;
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
        n_vec++; if (mem_wce !== 1'b0) begin n_err++; $display("FAIL reset_mem_wce got %b want 0", mem_wce); end
        n_vec++; if (mem_rce !== 1'b0) begin n_err++; $display("FAIL reset_mem_rce got %b want 0", mem_rce); end
        n_vec++; if (mem_wa !== 4'd0) begin n_err++; $display("FAIL reset_mem_wa got %0d want 0", mem_wa); end
        n_vec++; if (mem_ra !== 4'd0) begin n_err++; $display("FAIL reset_mem_ra got %0d want 0", mem_ra); end
`ifdef BRAM_FIFO_ALMOST_EN
        n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af got %b want 0", almost_full); end
        n_vec++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_ae got %b want 1", almost_empty); end
`endif
        rst_n = 1'b1; q.delete(); wr_total = 0;
        @(negedge clk); #1;
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_s_ready got %b want 1", s_ready); end
        @(negedge clk);
    endtask

    task automatic test_latency();
        s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1; #1;
        n_vec++; if (mem_wce !== 1'b1) begin n_err++; $display("FAIL lat_wce got %b want 1", mem_wce); end
        n_vec++; if (mem_wa !== 4'(wr_total)) begin n_err++; $display("FAIL lat_wa got %0d want %0d", mem_wa, wr_total % DEPTH); end
        adv(); s_valid = 1'b0; #1;
        n_vec++; if (mem_rce !== 1'b1) begin n_err++; $display("FAIL lat_t1_rce got %b want 1", mem_rce); end
        n_vec++; if (level !== 5'd1) begin n_err++; $display("FAIL lat_t1_level got %0d want 1", level); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL lat_t1_m_valid got %b want 0", m_valid); end
        adv(); #1;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL lat_t2_m_valid got %b want 0", m_valid); end
        n_vec++; if (level !== 5'd1) begin n_err++; $display("FAIL lat_t2_level got %0d want 1", level); end
        adv(); #1;
        n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL lat_t3_m_valid got %b want 1", m_valid); end
        n_vec++; if (m_data !== 8'hA5) begin n_err++; $display("FAIL lat_t3_m_data got %h want a5", m_data); end
        n_vec++; if (level !== 5'd1) begin n_err++; $display("FAIL lat_t3_level got %0d want 1", level); end
        adv(); #1;
        n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL lat_t4_level got %0d want 0", level); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL lat_t4_m_valid got %b want 0", m_valid); end
        m_ready = 1'b0;
    endtask

    task automatic test_fill_drain();
        int acc = 0;
        int exp = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1; s_data = 8'(i); #1;
            if (i >= CAP) begin
                n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL fill_s_ready_at_%0d got %b want 0", i, s_ready); end
            end
            if (s_valid && s_ready) acc++;
            adv();
        end
        s_valid = 1'b0; #1;
        n_vec++; if (acc != CAP) begin n_err++; $display("FAIL fill_accepted got %0d want %0d", acc, CAP); end
        n_vec++; if (level !== 5'(CAP)) begin n_err++; $display("FAIL fill_level got %0d want %0d", level, CAP); end
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL full_s_ready got %b want 0", s_ready); end
        m_ready = 1'b1;
        for (int c = 0; c < 60 && exp < CAP; c++) begin
            #1;
            n_vec++; if (level !== q.size()) begin n_err++; $display("FAIL drain_level got %0d want %0d", level, q.size()); end
            if (m_valid === 1'b1) begin
                n_vec++; if (m_data !== 8'(exp)) begin n_err++; $display("FAIL drain_data got %h want %h", m_data, 8'(exp)); end
                exp++;
            end
            adv();
        end
        #1;
        n_vec++; if (exp != CAP) begin n_err++; $display("FAIL drain_count got %0d want %0d", exp, CAP); end
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL drained_s_ready got %b want 1", s_ready); end
        n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL drained_level got %0d want 0", level); end
        m_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d = 8'h40;
        logic [DW-1:0] exp = 8'h40;
        bit acc;
        s_valid = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            s_data = d; #1;
            n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL b2b_s_ready_%0d got %b want 1", k, s_ready); end
            if (k >= 3) begin
                n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL b2b_m_valid_%0d got %b want 1", k, m_valid); end
            end
            if (m_valid === 1'b1) begin
                n_vec++; if (m_data !== exp) begin n_err++; $display("FAIL b2b_data_%0d got %h want %h", k, m_data, exp); end
                exp++;
            end
            acc = s_valid && s_ready;
            adv();
            if (acc) d++;
        end
        s_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (m_valid === 1'b1) begin
                n_vec++; if (m_data !== exp) begin n_err++; $display("FAIL b2b_tail got %h want %h", m_data, exp); end
                exp++;
            end
            adv();
        end
        #1;
        n_vec++; if (exp !== d) begin n_err++; $display("FAIL b2b_total got %h want %h", exp, d); end
        n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL b2b_level got %0d want 0", level); end
        m_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int pushed = 0;
        int popped = 0;
        for (int c = 0; c < 2000 && popped < 40; c++) begin
            s_valid = (pushed < 40) && ($urandom_range(1) == 1);
            s_data  = 8'($urandom);
            m_ready = $urandom_range(1) == 1;
            #1;
            n_vec++; if (level !== q.size()) begin n_err++; $display("FAIL rnd_level got %0d want %0d", level, q.size()); end
            if (mem_wce === 1'b1) begin
                n_vec++; if (mem_wa !== 4'(wr_total)) begin n_err++; $display("FAIL rnd_wa got %0d want %0d", mem_wa, wr_total % DEPTH); end
            end
            if (m_valid === 1'b1) begin
                n_vec++;
                if (q.size() == 0) begin n_err++; $display("FAIL rnd_valid_empty got %h want none", m_data); end
                else if (m_data !== q[0]) begin n_err++; $display("FAIL rnd_data got %h want %h", m_data, q[0]); end
            end
            if (s_valid && s_ready) pushed++;
            if (m_valid && m_ready) popped++;
            adv();
        end
        n_vec++; if (popped != 40) begin n_err++; $display("FAIL rnd_popped got %0d want 40", popped); end
        s_valid = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int got = 0;
        m_ready = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = 8'(8'h80 + i); #1;
            adv();
        end
        #1;
        n_vec++; if (level !== 5'd10) begin n_err++; $display("FAIL mid_level got %0d want 10", level); end
        rst_n = 1'b0; #1;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_m_valid got %b want 0", m_valid); end
        n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL mid_rst_level got %0d want 0", level); end
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_s_ready got %b want 0", s_ready); end
        q.delete(); wr_total = 0;
        @(negedge clk);
        rst_n = 1'b1; s_valid = 1'b0;
        @(negedge clk); #1;
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL mid_release_s_ready got %b want 1", s_ready); end
        n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL mid_release_level got %0d want 0", level); end
        m_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            s_valid = c < 3; s_data = 8'(8'h11 * (c + 1)); #1;
            if (m_valid === 1'b1) begin
                n_vec++;
                if (q.size() == 0) begin n_err++; $display("FAIL mid_stale got %h want none", m_data); end
                else if (m_data !== q[0]) begin n_err++; $display("FAIL mid_data got %h want %h", m_data, q[0]); end
                got++;
            end
            adv();
        end
        n_vec++; if (got != 3) begin n_err++; $display("FAIL mid_count got %0d want 3", got); end
        s_valid = 1'b0; m_ready = 1'b0;
    endtask

`ifdef BRAM_FIFO_ALMOST_EN
    task automatic test_almost();
        m_ready = 1'b0;
        for (int i = 0; i < CAP + 1; i++) begin
            s_valid = i < CAP; s_data = 8'(i); #1;
            n_vec++; if (level !== q.size()) begin n_err++; $display("FAIL alm_up_level got %0d want %0d", level, q.size()); end
            n_vec++; if (almost_full !== (q.size() >= 16)) begin n_err++; $display("FAIL alm_up_af at %0d got %b want %b", q.size(), almost_full, q.size() >= 16); end
            n_vec++; if (almost_empty !== (q.size() <= 1)) begin n_err++; $display("FAIL alm_up_ae at %0d got %b want %b", q.size(), almost_empty, q.size() <= 1); end
            adv();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            #1;
            n_vec++; if (almost_full !== (q.size() >= 16)) begin n_err++; $display("FAIL alm_dn_af at %0d got %b want %b", q.size(), almost_full, q.size() >= 16); end
            n_vec++; if (almost_empty !== (q.size() <= 1)) begin n_err++; $display("FAIL alm_dn_ae at %0d got %b want %b", q.size(), almost_empty, q.size() <= 1); end
            adv();
        end
        n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL alm_end_level got %0d want 0", level); end
        m_ready = 1'b0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_fill_drain();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef BRAM_FIFO_ALMOST_EN
        test_almost();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
